// File: rtl/dmux8way_buffered.sv
// dmux8way_buffered: registered 1-to-8 demultiplexer with one single-entry
// buffer per lane. A word accepted on the valid/ready input is steered by
// in_sel into one lane buffer. Each lane drains on its own valid/ready output.
// any_valid is the OR of the lane valids. occupancy is the number of full lanes.
//
// Optional feature: define DMUX8WAY_BCAST_EN to enable broadcast. With it,
// in_valid & in_bcast loads the word into all 8 lanes at once, and only when
// every lane can take it. Without it, in_bcast is ignored.

module dmux8way_buffered #(
   parameter int unsigned WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [2:0]         in_sel,
   input  logic               in_bcast,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [8*WIDTH-1:0] out_data,
   output logic [7:0]         out_valid,
   input  logic [7:0]         out_ready,
   output logic               any_valid,
   output logic [3:0]         occupancy
);

   // Lane state: a full flag and a data register per lane.
   logic [7:0]            full_q;
   logic [7:0]            full_d;
   logic [7:0][WIDTH-1:0] data_q;
   logic [7:0][WIDTH-1:0] data_d;
   logic [3:0]            occ_q;
   logic [3:0]            occ_d;

   logic [7:0] drain;
   logic [7:0] load;
   logic       lane_ok;
   logic       bcast_req;
   logic       xfer;

   // Count the set bits of a lane mask (result 0..8).
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, v[i]};
      end
      return cnt;
   endfunction

   // A lane drains when it holds data and its consumer is ready.
   assign drain = full_q & out_ready;

   // Selected lane can accept when empty or when it drains this same cycle.
   // This passes out_ready combinationally through to in_ready.
   assign lane_ok = ~full_q[in_sel] | out_ready[in_sel];

`ifdef DMUX8WAY_BCAST_EN
   logic all_ok;

   // Broadcast needs every lane free at once, so there is never a partial broadcast.
   assign all_ok    = &(~full_q | out_ready);
   assign bcast_req = in_valid & in_bcast;

   // Broadcast readiness overrides the per-lane view and ignores in_sel.
   always_comb begin
      in_ready = lane_ok;
      if (bcast_req) begin
         in_ready = all_ok;
      end
   end
`else
   logic unused_bcast;

   assign unused_bcast = in_bcast;
   assign bcast_req    = 1'b0;

   // Readiness depends only on the lane that in_sel addresses.
   always_comb begin
      in_ready = lane_ok;
   end
`endif

   assign xfer = in_valid & in_ready;

   // Decode which lanes take the incoming word this cycle.
   always_comb begin
      load = 8'h00;
      if (xfer) begin
         if (bcast_req) begin
            load = 8'hFF;
         end else begin
            load[in_sel] = 1'b1;
         end
      end
   end

   // Next lane state: a load wins over a drain, so drain+load stays full.
   always_comb begin
      full_d = load | (full_q & ~drain);
      data_d = data_q;
      for (int i = 0; i < 8; i++) begin
         if (load[i]) begin
            data_d[i] = in_data;
         end
      end
      occ_d = popcount8(full_d);
   end

   // Lane registers with asynchronous clear. Any held word is discarded on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 8'h00;
         data_q <= '0;
         occ_q  <= 4'd0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         occ_q  <= occ_d;
      end
   end

   assign out_valid = full_q;
   assign out_data  = data_q;
   assign occupancy = occ_q;
   assign any_valid = |full_q;

endmodule

// File: tb/tb_dmux8way_buffered.sv
// Testbench for dmux8way_buffered (WIDTH=8). It uses directed vectors with
// literal expectations. A lane-array model is checked against the DUT every cycle.
// The broadcast expectations follow DMUX8WAY_BCAST_EN when that macro is defined.

module tb_dmux8way_buffered;

   localparam int unsigned W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic [2:0]     in_sel = '0;
   logic           in_bcast = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [8*W-1:0] out_data;
   logic [7:0]     out_valid;
   logic [7:0]     out_ready = 8'h00;
   logic           any_valid;
   logic [3:0]     occupancy;

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   // Model: one flag and one word per lane.
   logic [7:0]   m_full = 8'h00;
   logic [W-1:0] m_data [8] = '{default: '0};

   dmux8way_buffered #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_bcast  (in_bcast),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .any_valid (any_valid),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic bit model_bcast();
`ifdef DMUX8WAY_BCAST_EN
      return in_valid && in_bcast;
`else
      return 1'b0;
`endif
   endfunction

   // The model accepts a word if every target lane is empty or being emptied now.
   function automatic bit model_ready();
      if (model_bcast()) begin
         for (int i = 0; i < 8; i++) begin
            if (m_full[i] && !out_ready[i]) return 1'b0;
         end
         return 1'b1;
      end
      return !m_full[in_sel] || out_ready[in_sel];
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(m_full[i]);
      return n;
   endfunction

   // Model state update: clears on reset. On each clock edge it drains lanes, then applies the load.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_full = 8'h00;
            for (int i = 0; i < 8; i++) m_data[i] = '0;
         end else begin
            bit take;
            bit bc;
            take = in_valid && model_ready();
            bc   = model_bcast();
            for (int i = 0; i < 8; i++) begin
               if (m_full[i] && out_ready[i]) m_full[i] = 1'b0;
            end
            if (take) begin
               for (int i = 0; i < 8; i++) begin
                  if (bc || (in_sel == 3'(i))) begin
                     m_full[i] = 1'b1;
                     m_data[i] = in_data;
                  end
               end
            end
         end
      end
   end

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_on) begin
         logic [8*W-1:0] exp_data;
         for (int i = 0; i < 8; i++) exp_data[i*W +: W] = m_data[i];
         check("m_out_valid", 64'(out_valid), 64'(m_full));
         check("m_occupancy", 64'(occupancy), 64'(model_count()));
         check("m_any_valid", 64'(any_valid), 64'(model_count() != 0));
         check("m_in_ready", 64'(in_ready), 64'(model_ready()));
         check("m_out_data", 64'(out_data), 64'(exp_data));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ready_all(input string name, input logic want);
      for (int s = 0; s < 8; s++) begin
         in_sel = 3'(s);
         #1;
         check(name, 64'(in_ready), 64'(want));
      end
   endtask

   function automatic logic [W-1:0] lane(input int i);
      return out_data[i*W +: W];
   endfunction

   initial begin
      #6 chk_on = 1'b1;
      #6 rst_n = 1'b1;
      tick();

      // Reset and idle state.
      check("rst_out_valid", 64'(out_valid), 64'h00);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_any_valid", 64'(any_valid), 64'd0);
      check_ready_all("rst_in_ready", 1'b1);

      // Single load into lane 3.
      in_valid = 1'b1; in_sel = 3'd3; in_data = 8'hA5; out_ready = 8'h00;
      tick();
      in_valid = 1'b0;
      check("ld_out_valid", 64'(out_valid), 64'h08);
      check("ld_lane3", 64'(lane(3)), 64'hA5);
      check("ld_occupancy", 64'(occupancy), 64'd1);
      check("ld_any_valid", 64'(any_valid), 64'd1);
      in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h55;
      #1;
      check("full_in_ready", 64'(in_ready), 64'd0);
      tick();
      in_valid = 1'b0;
      check("full_lane3_held", 64'(lane(3)), 64'hA5);

      // Drain and load on the same lane in one cycle.
      out_ready = 8'h08; in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h3C;
      #1;
      check("dl_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0; out_ready = 8'h00;
      check("dl_out_valid", 64'(out_valid), 64'h08);
      check("dl_lane3", 64'(lane(3)), 64'h3C);
      check("dl_occupancy", 64'(occupancy), 64'd1);

      // Empty lane 3, then fill all lanes.
      out_ready = 8'h08;
      tick();
      out_ready = 8'h00;
      check("drain_occupancy", 64'(occupancy), 64'd0);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_sel = 3'(i); in_data = 8'(8'h10 + i);
         tick();
      end
      in_valid = 1'b0;
      check("fill_occupancy", 64'(occupancy), 64'd8);
      check("fill_out_valid", 64'(out_valid), 64'hFF);
      check("fill_lane0", 64'(lane(0)), 64'h10);
      check("fill_lane7", 64'(lane(7)), 64'h17);
      check_ready_all("fill_in_ready", 1'b0);
      out_ready = 8'hFF;
      tick();
      out_ready = 8'h00;
      check("flush_out_valid", 64'(out_valid), 64'h00);
      check("flush_occupancy", 64'(occupancy), 64'd0);

      // Load lane 5 in the same cycle that lane 0 drains. Then reset asynchronously.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_sel = 3'(i); in_data = 8'(8'h20 + i);
         tick();
      end
      in_sel = 3'd5; in_data = 8'h25; out_ready = 8'h01;
      tick();
      in_valid = 1'b0; out_ready = 8'h00;
      check("ab_out_valid", 64'(out_valid), 64'h3E);
      check("ab_occupancy", 64'(occupancy), 64'd5);
      check("ab_lane5", 64'(lane(5)), 64'h25);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'h00);
      check("arst_occupancy", 64'(occupancy), 64'd0);
      check("arst_any_valid", 64'(any_valid), 64'd0);
      check("arst_lane1", 64'(lane(1)), 64'h00);
      #2 rst_n = 1'b1;
      tick();

      // Broadcast request from the empty state.
      in_valid = 1'b1; in_bcast = 1'b1; in_sel = 3'd2; in_data = 8'h7E; out_ready = 8'h00;
      tick();
      in_valid = 1'b0; in_bcast = 1'b0;
`ifdef DMUX8WAY_BCAST_EN
      check("bc_out_valid", 64'(out_valid), 64'hFF);
      check("bc_occupancy", 64'(occupancy), 64'd8);
      check("bc_lane0", 64'(lane(0)), 64'h7E);
      check("bc_lane7", 64'(lane(7)), 64'h7E);
`else
      check("bc_out_valid", 64'(out_valid), 64'h04);
      check("bc_occupancy", 64'(occupancy), 64'd1);
      check("bc_lane0", 64'(lane(0)), 64'h00);
`endif
      check("bc_lane2", 64'(lane(2)), 64'h7E);
      // Keep only lane 2 full, then broadcast again.
      out_ready = 8'hFB;
      tick();
      out_ready = 8'h00;
      in_valid = 1'b1; in_bcast = 1'b1; in_sel = 3'd2; in_data = 8'h11;
      #1;
      check("bc2_in_ready", 64'(in_ready), 64'd0);
      tick();
      in_valid = 1'b0; in_bcast = 1'b0;
      check("bc2_out_valid", 64'(out_valid), 64'h04);
      check("bc2_occupancy", 64'(occupancy), 64'd1);
      check("bc2_lane2", 64'(lane(2)), 64'h7E);
`ifdef DMUX8WAY_BCAST_EN
      check("bc2_lane0", 64'(lane(0)), 64'h7E);
`else
      check("bc2_lane0", 64'(lane(0)), 64'h00);
`endif

      // Mixed traffic, checked against the model only.
      for (int n = 0; n < 300; n++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_sel    = 3'($urandom_range(0, 7));
         in_data   = 8'($urandom);
         in_bcast  = ($urandom_range(0, 3) == 0);
         out_ready = 8'($urandom) & 8'($urandom);
         tick();
      end
      in_valid = 1'b0; in_bcast = 1'b0; out_ready = 8'h00;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmux8way_buffered.md
Name: dmux8way_buffered

Overview:
- Registered 1-to-8 demultiplexer: the fan-out counterpart of the 8-way OR reduction.
- Accepts one WIDTH-bit word per transfer on a valid/ready input.
- Steers the word by `sel` into one of 8 single-entry lane buffers. Each lane drains on its own valid/ready output.
- Provides `any_valid`, the 8-way OR of the lane valids, and an occupancy count for upstream flow control.

Parameters:
- WIDTH, 1, data bits per word (legal 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  3  target lane index 0..7.
- in_bcast  input  1  broadcast request (used only with the optional feature).
- in_valid  input  1  input word present.
- in_ready  output  1  input accepted this cycle when in_valid is also high.
- out_data  output  8*WIDTH  lane i data at bits [i*WIDTH +: WIDTH].
- out_valid  output  8  per-lane data present.
- out_ready  input  8  per-lane consumer ready.
- any_valid  output  1  OR of out_valid[7:0].
- occupancy  output  4  number of full lanes, 0..8.

Behaviour:
- Reset (rst_n low, asynchronous): all lane full flags 0, all lane data 0, out_valid=8'h00, occupancy=0, any_valid=0. Reset applies immediately mid-transfer; any word held in a lane is discarded.
- State per lane i: EMPTY or FULL.
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain+load, or on no activity.
- out_valid[i] = full[i], registered; out_data lane i comes directly from its register.
- Drain: out_valid[i] & out_ready[i] in cycle N -> lane i EMPTY in cycle N+1.
- Load (non-broadcast): in_valid & in_ready -> lane in_sel FULL with in_data at cycle N+1. Latency is 1 cycle.
- in_ready (non-broadcast) = ~full[in_sel] | out_ready[in_sel]. This is a combinational pass-through path from out_ready to in_ready.
- Simultaneous drain and load on the same lane: lane stays FULL, data replaced by in_data, out_valid stays 1.
- Loads to lane A while lane B drains are independent; both take effect the same edge.
- While out_valid[i] & ~out_ready[i], out_data lane i is held stable.
- in_sel values are don't-care when in_valid is 0; in_ready is still driven from in_sel.
- occupancy: registered popcount of next-state full flags, in step with out_valid.
- any_valid: combinational OR of out_valid; equals (occupancy != 0).
- Non-broadcast full case: all lanes FULL with no out_ready asserted -> in_ready=0 for every in_sel.

Optional Feature:
- Macro DMUX8WAY_BCAST_EN.
- Defined:
  - When in_valid & in_bcast, in_sel is ignored.
  - in_ready = AND over i of (~full[i] | out_ready[i]).
  - On transfer, all 8 lanes load in_data and go FULL; occupancy=8 next cycle.
  - Partial broadcast never occurs.
- Not defined: in_bcast is ignored entirely and every transfer is a non-broadcast load.
- No other behaviour differs.

Test Plan:
- Reset then idle, WIDTH=8 -> out_valid=00, occupancy=0, any_valid=0, in_ready=1 for all sel.
- Load 8'hA5 sel=3 with out_ready=00 -> next cycle out_valid=08, lane3=A5, occupancy=1, any_valid=1. Then load sel=3 again -> in_ready=0, lane3 still A5.
- Lane3 FULL with A5; drive out_ready=08 and load 8'h3C sel=3 in the same cycle -> in_ready=1, next cycle out_valid=08, lane3=3C, occupancy=1.
- Load sel=0..7 with data 10..17 on consecutive cycles, out_ready=00 -> occupancy=8, out_valid=FF, every in_ready=0. Then out_ready=FF for 1 cycle -> out_valid=00, occupancy=0.
- Assert rst_n low asynchronously mid-cycle with 5 lanes FULL -> out_valid=00 and occupancy=0 before the next clock edge.
- With DMUX8WAY_BCAST_EN: bcast 8'h7E with all lanes empty -> out_valid=FF, all lanes 7E. Then bcast with lane2 FULL and out_ready=00 -> in_ready=0 and no lane changes. Without the macro the same bcast stimulus loads lane in_sel only.
